mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits between the execute stage and wb_stage.
- Latches the execute-stage bus and waits for the data-SRAM load response.
- Performs load byte/halfword/LWL/LWR extraction, then forwards the 110-bit bus that wb_stage consumes.
- Supplies dependence/forwarding info to decode and handles exception/ERET flush, including dropping responses of cancelled loads.

Parameters:
ES_TO_MS_WD, 148, width of the incoming bus
MS_TO_WS_WD, 110, width of the outgoing bus
NO_EX, 5'h1F, ex_code value meaning "no exception"

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ms_allowin  out  1  stage can accept a new entry
es_to_ms_valid  in  1  execute stage offers an entry
es_to_ms_bus  in  148  {pc_error[147], BadVAddr[146:115], ex_code[114:110], eret[109], bd[108], mem_re[107], load_op[106:104], addr_low[103:102], rt_old[101:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ws_allowin  in  1  wb_stage can accept
ms_to_ws_valid  out  1  entry offered to wb_stage
ms_to_ws_bus  out  110  {pc_error, BadVAddr, ex_code, eret, bd, gr_we, dest, final_result, pc}
data_sram_data_ok  in  1  one-cycle load/store response strobe; in order, at most one outstanding
data_sram_rdata  in  32  response data, valid with data_ok
ws_ex  in  1  wb_stage is taking an exception (flush)
ws_eret  in  1  wb_stage is executing ERET (flush)
ms_ex  out  1  held entry has an exception or ERET; execute must suppress its memory request
MS_dest  out  5  dest & {5{ms_valid}}
MS_dest_data  out  32  final_result, for forwarding
MS_load_pending  out  1  ms_valid & wait_load & ~data_ready; decode must stall, not forward

Behaviour:
- Reset (async) state:
  - ms_valid=0, cancel=0, buf_valid=0, data_buf=0.
  - Bus register = 0, except ex_code = NO_EX.
  - All outputs follow from this: ms_to_ws_valid=0, MS_dest=0, MS_load_pending=0, ms_ex=0.
- Definitions:
  - flush = ws_ex | ws_eret.
  - wait_load = mem_re & (ex_code==NO_EX) & ~eret.
  - data_ready = buf_valid | (data_sram_data_ok & ~cancel).
- Handshake:
  - ms_ready_go = ~wait_load | data_ready.
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
  - Bus is captured when es_to_ms_valid & ms_allowin.
  - Latency: a non-load entry passes in 1 cycle. A load holds until data_ok; with data_ok in the cycle after capture, the load leaves 1 cycle later.
- ms_valid update, in priority order:
  - flush -> 0.
  - else if ms_allowin -> es_to_ms_valid.
- Response buffer:
  - If data_ok & ~cancel & ms_valid & wait_load & ~(ms_to_ws_valid & ws_allowin): data_buf <= rdata, buf_valid <= 1.
  - buf_valid clears on handoff to wb_stage or on flush.
  - Extraction uses data_buf when buf_valid, else data_sram_rdata.
- Cancel:
  - flush while ms_valid & wait_load & ~data_ready -> cancel <= 1.
  - The next data_ok with cancel=1 is discarded and clears cancel. It is never attributed to a newer entry.
  - data_ok arriving in the same cycle as flush completes the discarded load; no cancel is set.
- Load extraction, using addr_low a and loaded word d:
  - load_op 0 LW: d.
  - 1 LB / 2 LBU: byte a, sign- or zero-extended.
  - 3 LH / 4 LHU: halfword a[1], sign- or zero-extended.
  - 5 LWL:
    - a=0: {d[7:0], rt_old[23:0]}
    - a=1: {d[15:0], rt_old[15:0]}
    - a=2: {d[23:0], rt_old[7:0]}
    - a=3: d
  - 6 LWR:
    - a=0: d
    - a=1: {rt_old[31:24], d[31:8]}
    - a=2: {rt_old[31:16], d[31:16]}
    - a=3: {rt_old[31:8], d[31:24]}
  - 7: reserved, treated as LW.
- final_result = wait_load ? extracted : alu_result.
- Exceptions/ERET:
  - Exception fields pass through unchanged.
  - ms_ex = ms_valid & ((ex_code!=NO_EX) | eret).
- Store responses:
  - Execute issues store requests whose data_ok arrives while the store sits in this stage. mem_re=0, so the response is ignored, but a pending cancel still consumes it.

Test Plan:
- LW, pc=0xBFC00100, data_ok one cycle after capture with rdata=0x8000_00FF -> ms_to_ws_valid asserted with data_ok; final_result=0x800000FF; MS_load_pending=1 only in the capture cycle.
- LB a=3, rdata=0x80AB_CDEF -> 0xFFFF_FF80. LBU same -> 0x0000_0080. LH a=2 -> 0xFFFF_80AB. LWL a=1, rt_old=0x1122_3344 -> 0xCDEF_3344. LWR a=2 -> 0x1122_80AB.
- ws_allowin=0 when data_ok arrives with rdata=0x1234_5678; release 3 cycles later -> buffered 0x12345678 delivered; buf_valid cleared.
- Load waiting, ws_ex pulse, data_ok 2 cycles later while a new LW with different pc is held -> first response dropped, cancel cleared; new LW completes only on the second data_ok.
- Entry with ex_code=0x04 and mem_re=1 -> no wait, ms_ex=1, passes in 1 cycle with alu_result unchanged.
- Assert reset mid-load -> outputs zero immediately (asynchronous); ex_code field of ms_to_ws_bus reads 5'h1F.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: load response wait, extraction, flush/cancel
module mem_stage #(
    parameter int         ES_TO_MS_WD = 148,
    parameter int         MS_TO_WS_WD = 110,
    parameter logic [4:0] NO_EX       = 5'h1F
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ms_allowin,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_ex,
    input  logic                   ws_eret,
    output logic                   ms_ex,
    output logic [4:0]             MS_dest,
    output logic [31:0]            MS_dest_data,
    output logic                   MS_load_pending
);

    logic [ES_TO_MS_WD-1:0] es_bus;
    logic                   ms_valid;
    logic                   cancel;
    logic                   buf_valid;
    logic [31:0]            data_buf;

    logic        pc_error;
    logic [31:0] bad_vaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        bd;
    logic        mem_re;
    logic [2:0]  load_op;
    logic [1:0]  addr_low;
    logic [31:0] rt_old;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {pc_error, bad_vaddr, ex_code, eret, bd, mem_re, load_op, addr_low,
            rt_old, gr_we, dest, alu_result, pc} = es_bus;

    logic flush, wait_load, data_ready, ms_ready_go, handoff;
    logic [31:0] ld_word, extracted, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign flush          = ws_ex | ws_eret;
    assign wait_load      = mem_re & (ex_code == NO_EX) & ~eret;
    assign data_ready     = buf_valid | (data_sram_data_ok & ~cancel);
    assign ms_ready_go    = ~wait_load | data_ready;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign handoff        = ms_to_ws_valid & ws_allowin;

    assign ld_word = buf_valid ? data_buf : data_sram_rdata;
    assign ld_byte = ld_word[{addr_low, 3'b000} +: 8];
    assign ld_half = addr_low[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        extracted = ld_word;
        case (load_op)
            3'd1: extracted = {{24{ld_byte[7]}}, ld_byte};
            3'd2: extracted = {24'b0, ld_byte};
            3'd3: extracted = {{16{ld_half[15]}}, ld_half};
            3'd4: extracted = {16'b0, ld_half};
            3'd5: begin
                case (addr_low)
                    2'd0:    extracted = {ld_word[7:0],  rt_old[23:0]};
                    2'd1:    extracted = {ld_word[15:0], rt_old[15:0]};
                    2'd2:    extracted = {ld_word[23:0], rt_old[7:0]};
                    default: extracted = ld_word;
                endcase
            end
            3'd6: begin
                case (addr_low)
                    2'd0:    extracted = ld_word;
                    2'd1:    extracted = {rt_old[31:24], ld_word[31:8]};
                    2'd2:    extracted = {rt_old[31:16], ld_word[31:16]};
                    default: extracted = {rt_old[31:8],  ld_word[31:24]};
                endcase
            end
            default: extracted = ld_word;
        endcase
    end

    assign final_result = wait_load ? extracted : alu_result;

    assign ms_to_ws_bus    = {pc_error, bad_vaddr, ex_code, eret, bd, gr_we, dest, final_result, pc};
    assign ms_ex           = ms_valid & ((ex_code != NO_EX) | eret);
    assign MS_dest         = dest & {5{ms_valid}};
    assign MS_dest_data    = final_result;
    assign MS_load_pending = ms_valid & wait_load & ~data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            es_bus   <= '0;
            es_bus[114:110] <= NO_EX;
        end else begin
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid & ms_allowin)
                es_bus <= es_to_ms_bus;
        end
    end

    // A response that arrives while wb_stage stalls is parked so the data_ok strobe is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            data_buf  <= 32'b0;
        end else if (flush | handoff) begin
            buf_valid <= 1'b0;
        end else if (data_sram_data_ok & ~cancel & ms_valid & wait_load) begin
            buf_valid <= 1'b1;
            data_buf  <= data_sram_rdata;
        end
    end

    // The response of a flushed, still-outstanding load must be swallowed, never given to a newer entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cancel <= 1'b0;
        else if (flush & ms_valid & wait_load & ~data_ready)
            cancel <= 1'b1;
        else if (data_sram_data_ok & cancel)
            cancel <= 1'b0;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, corner sequences, random vs model
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [147:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [109:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_ex;
    logic         ws_eret;
    logic         ms_ex;
    logic [4:0]   MS_dest;
    logic [31:0]  MS_dest_data;
    logic         MS_load_pending;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_ex(ws_ex), .ws_eret(ws_eret), .ms_ex(ms_ex), .MS_dest(MS_dest),
        .MS_dest_data(MS_dest_data), .MS_load_pending(MS_load_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [31:0] rt;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [147:0] mk(input logic [4:0] ex, input logic er, input logic re,
                                        input logic [2:0] op, input logic [1:0] a, input logic [31:0] rt,
                                        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc);
        return {1'b0, 32'h0, ex, er, 1'b0, re, op, a, rt, 1'b1, dst, alu, pc};
    endfunction

    // Reference extraction from byte-lane arithmetic rather than per-case wiring.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rt, input logic [31:0] d);
        int ai;
        logic [31:0] ones, b, h;
        ai   = int'(a);
        ones = 32'hFFFF_FFFF;
        b    = (d >> (8 * ai)) & 32'hFF;
        h    = (d >> (16 * int'(a[1]))) & 32'hFFFF;
        case (op)
            3'd1: return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2: return b;
            3'd3: return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4: return h;
            3'd5: return (d << (8 * (3 - ai))) | (rt & (ones >> (8 * (ai + 1))));
            3'd6: return (d >> (8 * ai)) | (rt & ~(ones >> (8 * ai)));
            default: return d;
        endcase
    endfunction

    // Present one entry and return at the negedge right after it was captured.
    task automatic send(input logic [147:0] b);
        bit ok;
        ok = 0;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ms_allowin) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("send_allowin", ok, 1'b1);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
    endtask

    vec_t vt[17];

    initial begin
        logic [147:0] b;
        logic [109:0] eb;
        reset = 1'b1; es_to_ms_valid = 0; es_to_ms_bus = '0; ws_allowin = 1;
        data_sram_data_ok = 0; data_sram_rdata = 0; ws_ex = 0; ws_eret = 0;

        vt[0]  = '{3'd1, 2'd3, 32'h11223344, 32'h80ABCDEF, 32'hFFFFFF80};
        vt[1]  = '{3'd2, 2'd3, 32'h11223344, 32'h80ABCDEF, 32'h00000080};
        vt[2]  = '{3'd1, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'hFFFFFFEF};
        vt[3]  = '{3'd2, 2'd1, 32'h11223344, 32'h80ABCDEF, 32'h000000CD};
        vt[4]  = '{3'd3, 2'd2, 32'h11223344, 32'h80ABCDEF, 32'hFFFF80AB};
        vt[5]  = '{3'd4, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'h0000CDEF};
        vt[6]  = '{3'd3, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'hFFFFCDEF};
        vt[7]  = '{3'd5, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'hEF223344};
        vt[8]  = '{3'd5, 2'd1, 32'h11223344, 32'h80ABCDEF, 32'hCDEF3344};
        vt[9]  = '{3'd5, 2'd2, 32'h11223344, 32'h80ABCDEF, 32'hABCDEF44};
        vt[10] = '{3'd5, 2'd3, 32'h11223344, 32'h80ABCDEF, 32'h80ABCDEF};
        vt[11] = '{3'd6, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'h80ABCDEF};
        vt[12] = '{3'd6, 2'd1, 32'h11223344, 32'h80ABCDEF, 32'h1180ABCD};
        vt[13] = '{3'd6, 2'd2, 32'h11223344, 32'h80ABCDEF, 32'h112280AB};
        vt[14] = '{3'd6, 2'd3, 32'h11223344, 32'h80ABCDEF, 32'h11223380};
        vt[15] = '{3'd7, 2'd2, 32'h11223344, 32'h80ABCDEF, 32'h80ABCDEF};
        vt[16] = '{3'd0, 2'd0, 32'h11223344, 32'h80ABCDEF, 32'h80ABCDEF};

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_dest", MS_dest, 5'd0);
        chk("rst_pending", MS_load_pending, 1'b0);
        chk("rst_ms_ex", ms_ex, 1'b0);
        chk("rst_bus", ms_to_ws_bus, {1'b0, 32'h0, 5'h1F, 72'h0});
        chk("rst_allowin", ms_allowin, 1'b1);
        reset = 1'b0;

        // LW with response one cycle after capture
        send(mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd7, 32'h0, 32'hBFC00100));
        #1;
        chk("lw_pending_c1", MS_load_pending, 1'b1);
        chk("lw_valid_c1", ms_to_ws_valid, 1'b0);
        chk("lw_dest_c1", MS_dest, 5'd7);
        @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = 32'h800000FF; #1;
        chk("lw_valid_c2", ms_to_ws_valid, 1'b1);
        chk("lw_pending_c2", MS_load_pending, 1'b0);
        chk("lw_final", ms_to_ws_bus[63:32], 32'h800000FF);
        chk("lw_pc", ms_to_ws_bus[31:0], 32'hBFC00100);
        @(negedge clk); data_sram_data_ok = 0; #1;
        chk("lw_gone", ms_to_ws_valid, 1'b0);

        // extraction table
        foreach (vt[i]) begin
            send(mk(5'h1F, 0, 1, vt[i].op, vt[i].a, vt[i].rt, 5'd3, 32'h0, 32'h1000 + 32'(i)));
            @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = vt[i].d; #1;
            chk($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1'b1);
            chk($sformatf("vec%0d_final", i), ms_to_ws_bus[63:32], vt[i].exp);
            chk($sformatf("vec%0d_fwd", i), MS_dest_data, vt[i].exp);
            @(negedge clk); data_sram_data_ok = 0;
        end

        // wb_stage stall across the response: buffered data delivered later
        ws_allowin = 0;
        send(mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd4, 32'h0, 32'h2000));
        data_sram_data_ok = 1; data_sram_rdata = 32'h12345678; #1;
        chk("buf_valid_at_ok", ms_to_ws_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); data_sram_data_ok = 0; data_sram_rdata = 32'hDEAD0000; #1;
            chk("buf_hold_valid", ms_to_ws_valid, 1'b1);
            chk("buf_hold_final", ms_to_ws_bus[63:32], 32'h12345678);
        end
        @(negedge clk); ws_allowin = 1; #1;
        chk("buf_release_final", ms_to_ws_bus[63:32], 32'h12345678);
        send(mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd4, 32'h0, 32'h2004));
        #1;
        chk("buf_cleared_pending", MS_load_pending, 1'b1);
        @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = 32'h0BADF00D; #1;
        chk("buf_next_final", ms_to_ws_bus[63:32], 32'h0BADF00D);
        @(negedge clk); data_sram_data_ok = 0;

        // flush while waiting: stale response is dropped, not given to the next load
        send(mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd5, 32'h0, 32'h3000));
        #1; chk("cxl_pending", MS_load_pending, 1'b1);
        @(negedge clk); ws_ex = 1; #1;
        chk("cxl_flush_valid", ms_to_ws_valid, 1'b0);
        @(negedge clk); ws_ex = 0;
        es_to_ms_valid = 1; es_to_ms_bus = mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd6, 32'h0, 32'h3100); #1;
        chk("cxl_allowin", ms_allowin, 1'b1);
        @(negedge clk); es_to_ms_valid = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hAAAAAAAA; #1;
        chk("cxl_drop_valid", ms_to_ws_valid, 1'b0);
        chk("cxl_drop_pending", MS_load_pending, 1'b1);
        @(negedge clk); data_sram_rdata = 32'h00000055; #1;
        chk("cxl_new_valid", ms_to_ws_valid, 1'b1);
        chk("cxl_new_final", ms_to_ws_bus[63:32], 32'h00000055);
        chk("cxl_new_pc", ms_to_ws_bus[31:0], 32'h3100);
        @(negedge clk); data_sram_data_ok = 0;

        // excepting entry with mem_re set does not wait
        send(mk(5'h04, 0, 1, 3'd0, 2'd0, 32'h0, 5'd9, 32'hDEADBEEF, 32'h4000));
        #1;
        chk("exc_ms_ex", ms_ex, 1'b1);
        chk("exc_valid", ms_to_ws_valid, 1'b1);
        chk("exc_pending", MS_load_pending, 1'b0);
        chk("exc_final", ms_to_ws_bus[63:32], 32'hDEADBEEF);
        chk("exc_code", ms_to_ws_bus[76:72], 5'h04);
        @(negedge clk); #1;
        chk("exc_gone", ms_to_ws_valid, 1'b0);

        // random entries against the reference model
        for (int t = 0; t < 40; t++) begin
            logic [4:0] ex; logic er, re, is_load, got, done;
            logic [2:0] op; logic [1:0] a; logic [31:0] rt, alu, pc, d;
            logic [4:0] dst;
            ex  = ($urandom % 4 == 0) ? 5'($urandom_range(0, 30)) : 5'h1F;
            er  = ($urandom % 10 == 0);
            re  = ($urandom % 10 < 7);
            op  = 3'($urandom); a = 2'($urandom); rt = $urandom; alu = $urandom;
            pc  = $urandom; dst = 5'($urandom); d = 0;
            is_load = re && (ex == 5'h1F) && !er;
            got = 0; done = 0;
            ws_allowin = 1'($urandom);
            send(mk(ex, er, re, op, a, rt, dst, alu, pc));
            for (int k = 0; k < 60; k++) begin
                if (is_load && !got && ($urandom % 3 == 0)) begin
                    data_sram_data_ok = 1; d = $urandom; data_sram_rdata = d; got = 1;
                end else begin
                    data_sram_data_ok = 0; data_sram_rdata = $urandom;
                end
                ws_allowin = 1'($urandom);
                #1;
                chk("rnd_valid", ms_to_ws_valid, !is_load || got);
                chk("rnd_pending", MS_load_pending, is_load && !got);
                chk("rnd_ms_ex", ms_ex, (ex != 5'h1F) || er);
                if (ms_to_ws_valid && ws_allowin) begin
                    eb = {1'b0, 32'h0, ex, er, 1'b0, 1'b1, dst,
                          is_load ? ref_load(op, a, rt, d) : alu, pc};
                    chk("rnd_bus", ms_to_ws_bus, eb);
                    done = 1;
                end
                @(negedge clk);
                if (done) break;
            end
            data_sram_data_ok = 0;
            chk("rnd_done", done, 1'b1);
        end
        ws_allowin = 1;

        // asynchronous reset in the middle of a load
        send(mk(5'h1F, 0, 1, 3'd0, 2'd0, 32'h0, 5'd8, 32'h0, 32'h5000));
        #3; reset = 1'b1; #1;
        chk("arst_valid", ms_to_ws_valid, 1'b0);
        chk("arst_dest", MS_dest, 5'd0);
        chk("arst_pending", MS_load_pending, 1'b0);
        chk("arst_ms_ex", ms_ex, 1'b0);
        chk("arst_excode", ms_to_ws_bus[76:72], 5'h1F);
        chk("arst_bus", ms_to_ws_bus, {1'b0, 32'h0, 5'h1F, 72'h0});
        @(negedge clk); reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
